byte_scatter16: RTL and testbench

Stream byte scatter engine for the DMA datapath. It takes low-aligned packed byte beats (1..16 valid bytes each) and re-expands them onto 16-byte-lane output beats, one beat per requested lane mask. Bytes are placed in ascending order into the set lanes of each mask. It is the write-side counterpart of the byte-enable compaction path and sits between the packed data FIFO and the AXI write-data channel.

---
 rtl/byte_scatter_pkg.sv | 12 +
 rtl/byte_scatter16_if.sv | 31 +++
 rtl/lane_prefix16.sv | 22 ++
 rtl/byte_scatter16.sv | 133 +++++++++++++
 tb/tb_byte_scatter16.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_scatter_pkg.sv
// Shared types and sizes for the byte_scatter16 stream scatter engine.
package byte_scatter_pkg;

    localparam int unsigned LANES      = 16;
    localparam int unsigned DATA_WIDTH = LANES * 8;
    localparam int unsigned BUF_BYTES  = 32;

    typedef logic [LANES-1:0]      lane_mask_t;
    typedef logic [5:0]            level_t;
    typedef logic [LANES-1:0][3:0] lane_idx_t;

endpackage

// File: rtl/byte_scatter16_if.sv
// Packed-input, mask and scattered-output streams of byte_scatter16.
interface byte_scatter16_if;
    import byte_scatter_pkg::*;

    logic [DATA_WIDTH-1:0] s_data;
    logic [4:0]            s_cnt;
    logic                  s_valid;
    logic                  s_ready;

    lane_mask_t            mask;
    logic                  mask_last;
    logic                  mask_valid;
    logic                  mask_ready;

    logic [DATA_WIDTH-1:0] m_data;
    lane_mask_t            m_keep;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output s_data, s_cnt, s_valid, mask, mask_last, mask_valid, m_ready,
        input  s_ready, mask_ready, m_data, m_keep, m_last, m_valid
    );

    modport slave (
        input  s_data, s_cnt, s_valid, mask, mask_last, mask_valid, m_ready,
        output s_ready, mask_ready, m_data, m_keep, m_last, m_valid
    );

endinterface

// File: rtl/lane_prefix16.sv
// Exclusive prefix popcount of a 16-bit lane mask: per-lane source byte index plus total.
module lane_prefix16
    import byte_scatter_pkg::*;
(
    input  lane_mask_t mask,
    output lane_idx_t  idx,
    output logic [4:0] total
);

    logic [4:0] sum;

    always_comb begin
        sum = '0;
        idx = '0;
        for (int i = 0; i < LANES; i++) begin
            idx[i] = sum[3:0];
            sum    = sum + {4'b0, mask[i]};
        end
        total = sum;
    end

endmodule

// File: rtl/byte_scatter16.sv
// Scatters low-aligned packed bytes onto the set lanes of each requested mask.
// Define BYTE_SCATTER_OUT_REG_EN to add a 2-entry skid buffer behind the output register.
module byte_scatter16
    import byte_scatter_pkg::*;
(
    input logic             clk,
    input logic             rst,
    byte_scatter16_if.slave bus
);

    lane_idx_t  lane_idx;
    logic [4:0] pc;

    lane_prefix16 u_prefix (
        .mask  (bus.mask),
        .idx   (lane_idx),
        .total (pc)
    );

    logic [BUF_BYTES*8-1:0] buf_q, buf_d;
    level_t                 level_q, level_d, base;
    logic [4:0]             in_cnt;
    logic                   accept, fire, out_free, out_take;

    logic                  out_valid_q, out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    lane_mask_t            out_keep_q;

    assign bus.s_ready    = (level_q <= level_t'(16));
    assign accept         = bus.s_valid && bus.s_ready;
    assign in_cnt         = (bus.s_cnt > 5'd16) ? 5'd16 : bus.s_cnt;
    // Held low during reset so no mask is consumed while state is being cleared.
    assign fire           = !rst && bus.mask_valid && (level_q >= {1'b0, pc}) && out_free;
    assign bus.mask_ready = fire;

    always_comb begin
        out_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.mask[i]) begin
                out_data_d[i*8 +: 8] = buf_q[int'(lane_idx[i])*8 +: 8];
            end
        end
    end

    always_comb begin
        base  = level_q;
        buf_d = buf_q;
        if (fire) begin
            base  = level_q - level_t'(pc);
            buf_d = buf_q >> (int'(pc) * 8);
        end
        // accept implies level_q <= 16, so base + j stays inside the 32-byte buffer.
        for (int j = 0; j < LANES; j++) begin
            if (accept && (j < int'(in_cnt))) begin
                buf_d[(int'(base) + j)*8 +: 8] = bus.s_data[j*8 +: 8];
            end
        end
        level_d = base + (accept ? level_t'(in_cnt) : level_t'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q       <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
            if (fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_keep_q  <= bus.mask;
                out_last_q  <= bus.mask_last;
            end else if (out_take) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef BYTE_SCATTER_OUT_REG_EN
    logic [1:0]            sk_cnt_q;
    logic                  sk_rd_q, sk_wr_q, sk_push, sk_pop;
    logic [DATA_WIDTH-1:0] sk_data_q [2];
    lane_mask_t            sk_keep_q [2];
    logic                  sk_last_q [2];

    // Space is judged from registered count only, so m_ready stops at the skid buffer.
    assign out_take = out_valid_q && (sk_cnt_q != 2'd2);
    assign out_free = !out_valid_q || (sk_cnt_q != 2'd2);
    assign sk_push  = out_take;
    assign sk_pop   = (sk_cnt_q != 2'd0) && bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_cnt_q <= '0;
            sk_rd_q  <= 1'b0;
            sk_wr_q  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                sk_data_q[k] <= '0;
                sk_keep_q[k] <= '0;
                sk_last_q[k] <= 1'b0;
            end
        end else begin
            if (sk_push) begin
                sk_data_q[sk_wr_q] <= out_data_q;
                sk_keep_q[sk_wr_q] <= out_keep_q;
                sk_last_q[sk_wr_q] <= out_last_q;
                sk_wr_q            <= ~sk_wr_q;
            end
            if (sk_pop) begin
                sk_rd_q <= ~sk_rd_q;
            end
            sk_cnt_q <= sk_cnt_q + {1'b0, sk_push} - {1'b0, sk_pop};
        end
    end

    assign bus.m_valid = (sk_cnt_q != 2'd0);
    assign bus.m_data  = sk_data_q[sk_rd_q];
    assign bus.m_keep  = sk_keep_q[sk_rd_q];
    assign bus.m_last  = sk_last_q[sk_rd_q];
`else
    assign out_take    = bus.m_ready;
    assign out_free    = !out_valid_q || bus.m_ready;
    assign bus.m_valid = out_valid_q;
    assign bus.m_data  = out_data_q;
    assign bus.m_keep  = out_keep_q;
    assign bus.m_last  = out_last_q;
`endif

endmodule

// File: tb/tb_byte_scatter16.sv
// Bench for byte_scatter16: directed scenarios plus random traffic against a byte-stream model.
module tb_byte_scatter16;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   cnt;
    } in_item_t;

    typedef struct {
        logic [15:0] mask;
        logic        last;
    } mask_item_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_scatter16_if bus ();

    byte_scatter16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    in_item_t   in_q  [$];
    mask_item_t mk_q  [$];
    beat_t      exp_q [$];
    logic [7:0] byte_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int first_mv_cyc = 0;
    logic prev_mv = 1'b0;
    logic rnd_mode = 1'b0;
    logic mready_force = 1'b1;
    logic [127:0] last_data;
    logic [15:0]  last_keep;
    logic         last_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] start, input int n);
        logic [127:0] d = '0;
        for (int k = 0; k < n; k++) d[k*8 +: 8] = start + 8'(k);
        return d;
    endfunction

    function automatic logic [15:0] rand_mask(input int k);
        logic [15:0] m = '0;
        while ($countones(m) < k) m[$urandom_range(0, 15)] = 1'b1;
        return m;
    endfunction

    task automatic push_in(input logic [127:0] d, input logic [4:0] c);
        in_item_t it;
        it.data = d;
        it.cnt  = c;
        in_q.push_back(it);
    endtask

    task automatic push_mask(input logic [15:0] m, input logic l);
        mask_item_t it;
        it.mask = m;
        it.last = l;
        mk_q.push_back(it);
    endtask

    task automatic drive();
        if (in_q.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
            bus.s_valid = 1'b1;
            bus.s_data  = in_q[0].data;
            bus.s_cnt   = in_q[0].cnt;
        end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.s_cnt   = 5'($urandom_range(0, 31));
        end
        if (mk_q.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
            bus.mask_valid = 1'b1;
            bus.mask       = mk_q[0].mask;
            bus.mask_last  = mk_q[0].last;
        end else begin
            bus.mask_valid = 1'b0;
            bus.mask       = 16'($urandom);
            bus.mask_last  = 1'($urandom);
        end
        bus.m_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : mready_force;
    endtask

    // One clock: present stimulus, check against the model mid-cycle, apply handshakes.
    task automatic tick();
        logic  in_hs, mk_hs, out_hs, exp_fire;
        int    pc, n;
        beat_t b;
        drive();
        @(negedge clk);
        cyc++;
        pc = $countones(bus.mask);
        in_hs  = bus.s_valid && bus.s_ready;
        mk_hs  = bus.mask_valid && bus.mask_ready;
        out_hs = bus.m_valid && bus.m_ready;
        exp_fire = bus.mask_valid && (byte_q.size() >= pc) && (exp_q.size() == 0 || bus.m_ready);
        chk("s_ready", 128'(bus.s_ready), 128'(byte_q.size() <= 16));
        chk("m_valid", 128'(bus.m_valid), 128'(exp_q.size() != 0));
        chk("mask_ready", 128'(bus.mask_ready), 128'(exp_fire));
        if (bus.m_valid && exp_q.size() > 0) begin
            chk("m_data", bus.m_data, exp_q[0].data);
            chk("m_keep", 128'(bus.m_keep), 128'(exp_q[0].keep));
            chk("m_last", 128'(bus.m_last), 128'(exp_q[0].last));
        end
        if (out_hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            last_data = bus.m_data;
            last_keep = bus.m_keep;
            last_last = bus.m_last;
        end
        if (bus.m_valid && !prev_mv) first_mv_cyc = cyc;
        prev_mv = bus.m_valid;
        if (mk_hs) begin
            b.data = '0;
            b.keep = bus.mask;
            b.last = bus.mask_last;
            for (int i = 0; i < 16; i++) begin
                if (bus.mask[i]) b.data[i*8 +: 8] = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
            end
            exp_q.push_back(b);
            if (mk_q.size() > 0) void'(mk_q.pop_front());
        end
        if (in_hs) begin
            n = (bus.s_cnt > 5'd16) ? 16 : int'(bus.s_cnt);
            for (int k = 0; k < n; k++) byte_q.push_back(bus.s_data[k*8 +: 8]);
            if (in_q.size() > 0) void'(in_q.pop_front());
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        int left = budget;
        while ((in_q.size() > 0 || mk_q.size() > 0 || exp_q.size() > 0) && left > 0) begin
            tick();
            left--;
        end
        chk("idle_timeout", 128'(in_q.size() + mk_q.size() + exp_q.size()), 128'(0));
    endtask

    initial begin
        int total, rem, k, c;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_cnt      = '0;
        bus.mask_valid = 1'b0;
        bus.mask       = '0;
        bus.mask_last  = 1'b0;
        bus.m_ready    = 1'b1;
        #2;
        chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
        chk("rst_m_data", bus.m_data, 128'(0));
        chk("rst_m_keep", 128'(bus.m_keep), 128'(0));
        chk("rst_m_last", 128'(bus.m_last), 128'(0));
        chk("rst_s_ready", 128'(bus.s_ready), 128'(1));
        chk("rst_mask_ready", 128'(bus.mask_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-beat pass-through and latency
        push_in(ramp(8'h00, 16), 5'd16);
        push_mask(16'hFFFF, 1'b1);
        run_until_idle(20);
        chk("t1_data", last_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t1_keep", 128'(last_keep), 128'hFFFF);
        chk("t1_last", 128'(last_last), 128'(1));
        chk("t1_latency", 128'(first_mv_cyc - last_acc_cyc), 128'(2));

        // Mid-lane placement
        push_in(ramp(8'hA0, 4), 5'd4);
        push_mask(16'h00F0, 1'b0);
        run_until_idle(20);
        chk("t2_data", last_data, 128'h0000000000000000A3A2A1A000000000);
        chk("t2_keep", 128'(last_keep), 128'h00F0);

        // Sparse mask then empty mask
        push_in(128'h2211, 5'd2);
        push_mask(16'h8001, 1'b0);
        run_until_idle(20);
        chk("t3_data", last_data, 128'h22000000000000000000000000000011);
        push_mask(16'h0000, 1'b1);
        run_until_idle(20);
        chk("t3_zero_data", last_data, 128'(0));
        chk("t3_zero_keep", 128'(last_keep), 128'(0));

        // Underflow wait
        push_in(ramp(8'h00, 10), 5'd10);
        push_mask(16'hFFFF, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_waiting", 128'(mk_q.size()), 128'(1));
        push_in(ramp(8'h0A, 6), 5'd6);
        run_until_idle(20);
        chk("t4_data", last_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // Backpressure
        mready_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_in(ramp(8'(8'h40 + i * 16), 16), 5'd16);
            push_mask(16'h000F, 1'b0);
        end
        for (int i = 0; i < 6; i++) tick();
        chk("t5_s_ready_low", 128'(bus.s_ready), 128'(0));
        chk("t5_m_valid_held", 128'(bus.m_valid), 128'(1));
        mready_force = 1'b1;
        push_mask(16'hFFFF, 1'b0);
        push_mask(16'hFFFF, 1'b0);
        push_mask(16'h000F, 1'b1);
        run_until_idle(50);
        chk("t5_final", last_data, 128'(128'h6F6E6D6C));

        // Mid-operation reset with level 20 and a beat pending
        mready_force = 1'b0;
        push_in(ramp(8'h00, 16), 5'd16);
        push_in(ramp(8'h10, 8), 5'd8);
        push_mask(16'h000F, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        bus.mask_valid = 1'b1;
        bus.mask       = 16'h0000;
        bus.m_ready    = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_m_valid", 128'(bus.m_valid), 128'(0));
        chk("t6_m_data", bus.m_data, 128'(0));
        chk("t6_m_keep", 128'(bus.m_keep), 128'(0));
        chk("t6_m_last", 128'(bus.m_last), 128'(0));
        chk("t6_s_ready", 128'(bus.s_ready), 128'(1));
        chk("t6_mask_ready", 128'(bus.mask_ready), 128'(0));
        in_q.delete();
        mk_q.delete();
        exp_q.delete();
        byte_q.delete();
        prev_mv = 1'b0;
        bus.mask_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mready_force = 1'b1;
        push_in(ramp(8'h50, 4), 5'd4);
        push_mask(16'h000F, 1'b0);
        run_until_idle(20);
        chk("t6_fresh", last_data, 128'h53525150);

        // Random traffic, mask demand matched to supplied bytes
        rnd_mode = 1'b1;
        total = 0;
        for (int i = 0; i < 80; i++) begin
            c = $urandom_range(0, 20);
            push_in({$urandom, $urandom, $urandom, $urandom}, 5'(c));
            total += (c > 16) ? 16 : c;
        end
        rem = total;
        while (rem > 0) begin
            k = $urandom_range(0, (rem < 16) ? rem : 16);
            push_mask(rand_mask(k), 1'($urandom));
            rem -= k;
        end
        run_until_idle(20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
